prog_mem_responder: RTL and testbench
=====================================

Name: prog_mem_responder

Overview:
- Responder-side memory block for the CPU's instruction or data memory port (addr / rd_en / wr_en / data_in / data_out).
- Adds a host load port with a valid/ready handshake, so a program or data image is streamed in before the CPU is started.
- Sits between a host/testbench loader and the CPU.
- Serves CPU reads with one-cycle registered latency; blocks CPU accesses while loading.

Parameters:
- DATA_WIDTH, 10, word width of the array, load port and CPU port
- MEM_DEPTH, 8, number of words
- ADDR_WIDTH, 3, address width; MEM_DEPTH equals 2**ADDR_WIDTH
- CNT_WIDTH, 4, width of the dropped-access counter

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  single-cycle request to begin a full image load
- load_valid  in  1  load_data is valid this cycle
- load_data  in  DATA_WIDTH  image word
- load_ready  out  1  block accepts a load word this cycle
- load_done  out  1  single-cycle pulse after the last word is written
- busy  out  1  high while in LOAD
- addr  in  ADDR_WIDTH  CPU word address
- rd_en  in  1  CPU read request
- wr_en  in  1  CPU write request
- data_in  in  DATA_WIDTH  CPU write data
- data_out  out  DATA_WIDTH  registered read data
- rd_valid  out  1  data_out updated with the read issued in the previous cycle
- drop_cnt  out  CNT_WIDTH  saturating count of CPU requests rejected during LOAD

Behaviour:
- Reset is synchronous and active-high. While rst=1 at a clock edge:
  - state goes to IDLE, load pointer to 0.
  - Every array word goes to 0.
  - data_out=0, rd_valid=0, load_ready=0, load_done=0, busy=0, drop_cnt=0.
- States are IDLE, LOAD, RUN.
- IDLE:
  - CPU port is served as in RUN; the array reads as zeros until loaded.
  - load_start=1 -> LOAD with pointer 0.
- LOAD:
  - busy=1 and load_ready=1 combinationally from state.
  - On load_valid & load_ready: mem[ptr] <= load_data, ptr increments.
  - Acceptance of the word at ptr = MEM_DEPTH-1 -> RUN; load_done=1 for the following cycle only.
  - load_valid=0 stalls with no timeout; ptr holds.
  - load_start while in LOAD is ignored.
- RUN:
  - load_start=1 -> LOAD with ptr 0 (reload).
  - Array contents are retained until overwritten.
- CPU port (IDLE/RUN):
  - rd_en at edge N -> data_out = mem[addr] and rd_valid=1 at edge N+1.
  - rd_valid is a single-cycle pulse per request; back-to-back reads give one result per cycle.
  - data_out holds its last value when no read is issued.
  - wr_en at edge N -> mem[addr] <= data_in at edge N.
  - rd_en & wr_en to the same addr in the same cycle: read-before-write. data_out returns the old word; the new word is visible to the next read.
- CPU port during LOAD:
  - rd_en or wr_en is dropped: no array access, rd_valid stays 0, data_out holds.
  - drop_cnt increments once per cycle with rd_en|wr_en and saturates at all-ones.
  - drop_cnt clears only on rst.
- Cycle that enters LOAD from RUN: a CPU request in that same cycle (state still RUN) is served.
- Reset mid-load discards the partial image: array cleared, state IDLE, no load_done pulse.
- Address is always in range because MEM_DEPTH=2**ADDR_WIDTH; no bounds checking.

Test Plan:
- Reset then read addr 5 in IDLE -> rd_valid one cycle later, data_out=0; drop_cnt=0.
- Pulse load_start, stream 8 words 0x101..0x108 with valid every cycle -> load_ready high for 8 cycles, load_done pulse one cycle after the 8th accept, busy falls. Reads of addr 0..7 then return 0x101..0x108, one per cycle with rd_valid each cycle.
- Load with load_valid toggled 1,0,1,0 -> exactly 8 words written in order; ptr holds on gaps; load_done after the last accepted word only.
- In RUN with mem[3]=0x104: rd_en & wr_en at addr 3, data_in=0x2AA -> data_out=0x104. Next read of addr 3 -> 0x2AA.
- During LOAD, drive rd_en for 20 cycles -> rd_valid stays 0, data_out unchanged, drop_cnt saturates at 15.
- Assert rst after 4 load words -> state IDLE, busy=0, no load_done; read addr 2 returns 0.

Source files
------------

// File: rtl/prog_mem_responder.sv
// Word-addressed memory serving a CPU port, with a host load port that streams
// a full image in before the CPU runs. CPU accesses are refused while loading.
module prog_mem_responder #(
    parameter int DATA_WIDTH = 10,
    parameter int MEM_DEPTH  = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  ptr_q;
    logic                   load_done_q;
    logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]  data_out_q;
    logic                   rd_valid_q;
    logic [CNT_WIDTH-1:0]   drop_cnt_q;
    logic [CNT_WIDTH-1:0]   drop_cnt_d;

    logic in_load;
    logic load_we;
    logic cpu_rd;
    logic cpu_we;
    logic cpu_req;

    assign in_load = (state_q == ST_LOAD);
    assign load_we = in_load && load_valid;
    assign cpu_rd  = !in_load && rd_en;
    assign cpu_we  = !in_load && wr_en;
    assign cpu_req = rd_en || wr_en;

    assign load_ready = in_load;
    assign busy       = in_load;
    assign load_done  = load_done_q;
    assign data_out   = data_out_q;
    assign rd_valid   = rd_valid_q;
    assign drop_cnt   = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q <= ST_LOAD;
                        ptr_q   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (ptr_q == LAST_PTR) begin
                            state_q     <= ST_RUN;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (load_start) begin
                        state_q <= ST_LOAD;
                        ptr_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    // Per-word registers so the whole array can clear on reset; the load port
    // and the CPU port never write in the same cycle because they depend on state.
    generate
        for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (load_we && (ptr_q == ADDR_WIDTH'(gi))) begin
                    mem_q[gi] <= load_data;
                end else if (cpu_we && (addr == ADDR_WIDTH'(gi))) begin
                    mem_q[gi] <= data_in;
                end
            end
        end
    endgenerate

    // Read samples the pre-write word, giving read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= cpu_rd;
            if (cpu_rd) begin
                data_out_q <= mem_q[addr];
            end
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_load && cpu_req && (drop_cnt_q != {CNT_WIDTH{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed bench for prog_mem_responder: inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_prog_mem_responder;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic [9:0]  load_data;
    logic        load_ready;
    logic        load_done;
    logic        busy;
    logic [2:0]  addr;
    logic        rd_en;
    logic        wr_en;
    logic [9:0]  data_in;
    logic [9:0]  data_out;
    logic        rd_valid;
    logic [3:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    prog_mem_responder #(
        .DATA_WIDTH(10),
        .MEM_DEPTH (8),
        .ADDR_WIDTH(3),
        .CNT_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .load_done (load_done),
        .busy      (busy),
        .addr      (addr),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        addr = '0; rd_en = 1'b0; wr_en = 1'b0; data_in = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_load_ready", 32'(load_ready), 32'h0);
        check("rst_load_done", 32'(load_done), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);

        // IDLE read of an unloaded word
        rd_en = 1'b1; addr = 3'd5;
        tick();
        $display("idle read addr 5: data_out=%0h rd_valid=%0b", data_out, rd_valid);
        check("idle_rd_valid", 32'(rd_valid), 32'h1);
        check("idle_rd_data", 32'(data_out), 32'h0);
        rd_en = 1'b0;
        tick();
        check("idle_rd_valid_pulse", 32'(rd_valid), 32'h0);

        // full load, valid every cycle
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1; load_data = 10'(32'h101 + i);
            check("load_ready_stream", 32'(load_ready), 32'h1);
            check("load_done_early", 32'(load_done), 32'h0);
            tick();
            $display("load word %0d = %0h", i, load_data);
        end
        load_valid = 1'b0;
        check("load_done_pulse", 32'(load_done), 32'h1);
        check("load_busy_fall", 32'(busy), 32'h0);
        check("load_ready_fall", 32'(load_ready), 32'h0);
        tick();
        check("load_done_single", 32'(load_done), 32'h0);

        // back-to-back reads of the image
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; addr = 3'(i);
            tick();
            $display("read addr %0d: data_out=%0h rd_valid=%0b", i, data_out, rd_valid);
            check("run_rd_valid", 32'(rd_valid), 32'h1);
            check("run_rd_data", 32'(data_out), 32'h101 + 32'(i));
        end
        rd_en = 1'b0;
        tick();
        check("run_rd_valid_idle", 32'(rd_valid), 32'h0);
        check("run_data_hold", 32'(data_out), 32'h108);

        // read-before-write collision
        rd_en = 1'b1; wr_en = 1'b1; addr = 3'd3; data_in = 10'h2AA;
        tick();
        $display("rd+wr addr 3: data_out=%0h", data_out);
        check("raw_old_data", 32'(data_out), 32'h104);
        wr_en = 1'b0;
        tick();
        $display("reread addr 3: data_out=%0h", data_out);
        check("raw_new_data", 32'(data_out), 32'h2AA);
        check("run_drop_cnt_zero", 32'(drop_cnt), 32'h0);

        // reload from RUN with a same-cycle read that must be served
        rd_en = 1'b1; addr = 3'd0; load_start = 1'b1;
        tick();
        rd_en = 1'b0; load_start = 1'b0;
        check("reload_entry_rd_valid", 32'(rd_valid), 32'h1);
        check("reload_entry_rd_data", 32'(data_out), 32'h101);
        check("reload_busy", 32'(busy), 32'h1);
        check("reload_drop_cnt", 32'(drop_cnt), 32'h0);
        for (int k = 0; k < 16; k++) begin
            load_valid = (k % 2 == 0);
            load_data = 10'(32'h200 + k / 2);
            tick();
            $display("gappy load step %0d valid=%0b load_done=%0b", k, load_valid, load_done);
            check("gap_load_done", 32'(load_done), (k == 14) ? 32'h1 : 32'h0);
            check("gap_busy", 32'(busy), (k < 14) ? 32'h1 : 32'h0);
        end
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; addr = 3'(i);
            tick();
            $display("read addr %0d: data_out=%0h", i, data_out);
            check("gap_rd_data", 32'(data_out), 32'h200 + 32'(i));
        end
        rd_en = 1'b0;

        // CPU reads dropped while loading
        load_start = 1'b1;
        tick();
        load_start = 1'b0; rd_en = 1'b1; addr = 3'd1;
        for (int i = 0; i < 20; i++) begin
            tick();
            $display("dropped read %0d: rd_valid=%0b drop_cnt=%0d", i, rd_valid, drop_cnt);
            check("drop_rd_valid", 32'(rd_valid), 32'h0);
            check("drop_data_hold", 32'(data_out), 32'h207);
            check("drop_cnt", 32'(drop_cnt), (i < 15) ? 32'(i + 1) : 32'd15);
        end
        rd_en = 1'b0;

        // reset partway through a load
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = 10'(32'h3F0 + i);
            tick();
        end
        load_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("reset mid-load: busy=%0b load_done=%0b drop_cnt=%0d", busy, load_done, drop_cnt);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_load_done", 32'(load_done), 32'h0);
        check("midrst_load_ready", 32'(load_ready), 32'h0);
        check("midrst_drop_cnt", 32'(drop_cnt), 32'h0);
        check("midrst_data_out", 32'(data_out), 32'h0);
        rd_en = 1'b1; addr = 3'd2;
        tick();
        rd_en = 1'b0;
        $display("post-reset read addr 2: data_out=%0h rd_valid=%0b", data_out, rd_valid);
        check("midrst_rd_valid", 32'(rd_valid), 32'h1);
        check("midrst_rd_data", 32'(data_out), 32'h0);
        check("midrst_no_done", 32'(load_done), 32'h0);
        rd_en = 1'b1; addr = 3'd7;
        tick();
        rd_en = 1'b0;
        check("midrst_rd_data7", 32'(data_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
